// File: rtl/hex_scan_mux.sv
// hex_scan_mux
//   Multiplexed seven-segment scanner for NUM_DIGITS hex digits. One digit is
//   driven per time slot of SCAN_DIV clocks. The scanner supports a decimal
//   point per digit, blanking per digit, leading-zero suppression and PWM
//   brightness. New display contents are loaded through a frame-synchronous
//   load/ack handshake, so a digit never changes halfway through a frame.
//
//   Optional feature macro: SEG_BLINK_EN. Defining it adds the blink_mask input
//   and the BLINK_FRAMES parameter. Masked digits blink with a period set in
//   frames.
//
// Ports
//   Clk          in   system clock
//   Rst          in   synchronous active-high reset
//   disp_data    in   nibble i drives digit i (digit 0 = LSB)
//   dp_in        in   decimal point per digit (1 = lit)
//   blank_in     in   force digit dark (1 = blank)
//   lz_blank     in   enable leading-zero suppression (live, not captured)
//   brightness   in   PWM duty: 0 = off, all-ones = always on
//   load         in   pulse: capture disp_data/dp_in/blank_in(/blink_mask)
//   blink_mask   in   (SEG_BLINK_EN only) digits that blink
//   load_ack     out  1-clk pulse: captured values are now displayed
//   frame_start  out  1-clk pulse after the digit index wraps to 0
//   sel          out  one-hot digit enable, polarity set by ACTIVE_LOW
//   seg          out  {dp,g,f,e,d,c,b,a}, polarity set by ACTIVE_LOW
//
// Handshake: load is sampled on every clock and needs no ready signal.
//   load_ack is a single-cycle strobe. It fires one clock after the frame
//   boundary on which the staged contents move into the display shadow.
//   Several loads inside one frame collapse into one ack (last load wins).
module hex_scan_mux #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 100000,
    parameter int BRIGHT_W   = 4,
    parameter int ACTIVE_LOW = 1
`ifdef SEG_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 256
`endif
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [4*NUM_DIGITS-1:0] disp_data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lz_blank,
    input  logic [BRIGHT_W-1:0]     brightness,
    input  logic                    load,
`ifdef SEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic                    load_ack,
    output logic                    frame_start,
    output logic [NUM_DIGITS-1:0]   sel,
    output logic [7:0]              seg
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int DIV_W = $clog2(SCAN_DIV);

    localparam logic [NUM_DIGITS-1:0] SEL_OFF = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [7:0]            SEG_OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    // Scan counters
    logic [DIV_W-1:0]    div_cnt;
    logic [IDX_W-1:0]    idx;
    logic [BRIGHT_W-1:0] pwm_cnt;
    logic                div_last;
    logic                boundary;

    // Staging (written by load) and shadow (what is displayed)
    logic [4*NUM_DIGITS-1:0] stg_data, shd_data;
    logic [NUM_DIGITS-1:0]   stg_dp, shd_dp;
    logic [NUM_DIGITS-1:0]   stg_blank, shd_blank;
    logic                    pending;

    assign div_last = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign boundary = div_last && (idx == IDX_W'(NUM_DIGITS - 1));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            div_cnt <= '0;
            idx     <= '0;
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (div_last) begin
                div_cnt <= '0;
                idx     <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // A load on the boundary cycle skips staging and goes straight to the
    // shadow. It overrides anything still pending.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            stg_data    <= '0;
            stg_dp      <= '0;
            stg_blank   <= '0;
            shd_data    <= '0;
            shd_dp      <= '0;
            shd_blank   <= '0;
            pending     <= 1'b0;
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            load_ack    <= boundary && (load || pending);
            frame_start <= boundary;
            if (load && boundary) begin
                shd_data  <= disp_data;
                shd_dp    <= dp_in;
                shd_blank <= blank_in;
                pending   <= 1'b0;
            end else if (load) begin
                stg_data  <= disp_data;
                stg_dp    <= dp_in;
                stg_blank <= blank_in;
                pending   <= 1'b1;
            end else if (boundary && pending) begin
                shd_data  <= stg_data;
                shd_dp    <= stg_dp;
                shd_blank <= stg_blank;
                pending   <= 1'b0;
            end
        end
    end

`ifdef SEG_BLINK_EN
    localparam int FRM_W = $clog2(BLINK_FRAMES + 1);

    logic [NUM_DIGITS-1:0] stg_blink, shd_blink;
    logic [FRM_W-1:0]      frame_cnt;
    logic                  blink_phase;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            stg_blink   <= '0;
            shd_blink   <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b1;
        end else begin
            if (load && boundary)
                shd_blink <= blink_mask;
            else if (load)
                stg_blink <= blink_mask;
            else if (boundary && pending)
                shd_blink <= stg_blink;

            if (boundary) begin
                if (frame_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end
`endif

    // Active-low segment code {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] hex_code(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_code = 7'h40;
            4'h1:    hex_code = 7'h79;
            4'h2:    hex_code = 7'h24;
            4'h3:    hex_code = 7'h30;
            4'h4:    hex_code = 7'h19;
            4'h5:    hex_code = 7'h12;
            4'h6:    hex_code = 7'h02;
            4'h7:    hex_code = 7'h78;
            4'h8:    hex_code = 7'h00;
            4'h9:    hex_code = 7'h10;
            4'hA:    hex_code = 7'h08;
            4'hB:    hex_code = 7'h03;
            4'hC:    hex_code = 7'h46;
            4'hD:    hex_code = 7'h21;
            4'hE:    hex_code = 7'h06;
            default: hex_code = 7'h0E;
        endcase
    endfunction

    // zero_run[i]: digits i..NUM_DIGITS-1 all show 0 with the dp clear.
    logic [NUM_DIGITS-1:0] zero_run;

    always_comb begin
        zero_run = '0;
        zero_run[NUM_DIGITS-1] = (shd_data[4*(NUM_DIGITS-1) +: 4] == 4'h0)
                                 && !shd_dp[NUM_DIGITS-1];
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            zero_run[i] = zero_run[i+1] && (shd_data[4*i +: 4] == 4'h0) && !shd_dp[i];
        end
    end

    logic [3:0]            cur_nib;
    logic                  gate_open;
    logic                  blink_dark;
    logic                  dark;
    logic [NUM_DIGITS-1:0] sel_low;
    logic [7:0]            seg_low;

    always_comb begin
        cur_nib   = shd_data[4*idx +: 4];
        gate_open = (brightness == '1) || (pwm_cnt < brightness);
`ifdef SEG_BLINK_EN
        blink_dark = shd_blink[idx] && !blink_phase;
`else
        blink_dark = 1'b0;
`endif
        dark = shd_blank[idx]
               || (lz_blank && (idx != '0) && zero_run[idx])
               || !gate_open
               || blink_dark;
        if (dark) begin
            sel_low = '1;
            seg_low = 8'hFF;
        end else begin
            sel_low = ~(NUM_DIGITS'(1) << idx);
            seg_low = {~shd_dp[idx], hex_code(cur_nib)};
        end
    end

    // Output register: pins change one clock after idx/pwm_cnt change.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sel <= SEL_OFF;
            seg <= SEG_OFF;
        end else if (ACTIVE_LOW != 0) begin
            sel <= sel_low;
            seg <= seg_low;
        end else begin
            sel <= ~sel_low;
            seg <= ~seg_low;
        end
    end

endmodule

// File: tb/tb_hex_scan_mux.sv
// tb_hex_scan_mux
//   Bench for hex_scan_mux with 4 digits, 4 clocks per slot and 2-bit
//   brightness. On every clock a reference model pushes the expected
//   {load_ack, frame_start, sel, seg}. A monitor on the falling edge pops each
//   entry and compares it with the DUT.
module tb_hex_scan_mux;

    localparam int N  = 4;
    localparam int SD = 4;
    localparam int BW = 2;
    localparam int FRAME = N * SD;
    localparam int W  = 2 + N + 8;

    logic          clk;
    logic          rst;
    logic [4*N-1:0] disp_data;
    logic [N-1:0]  dp_in;
    logic [N-1:0]  blank_in;
    logic          lz_blank;
    logic [BW-1:0] brightness;
    logic          load;
    logic          load_ack;
    logic          frame_start;
    logic [N-1:0]  sel;
    logic [7:0]    seg;
`ifdef SEG_BLINK_EN
    logic [N-1:0]  blink_mask;
    initial blink_mask = '0;
`endif

    int n_cmp;
    int n_err;

    logic [W-1:0] exp_q[$];

    hex_scan_mux #(
        .NUM_DIGITS(N),
        .SCAN_DIV(SD),
        .BRIGHT_W(BW),
        .ACTIVE_LOW(1)
    ) dut (
        .Clk(clk),
        .Rst(rst),
        .disp_data(disp_data),
        .dp_in(dp_in),
        .blank_in(blank_in),
        .lz_blank(lz_blank),
        .brightness(brightness),
        .load(load),
`ifdef SEG_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .load_ack(load_ack),
        .frame_start(frame_start),
        .sel(sel),
        .seg(seg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Active-low segment code for each hex value with the dp off.
    function automatic logic [7:0] seg_of(input int v);
        case (v)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90; 10: return 8'h88; 11: return 8'h83;
           12: return 8'hC6; 13: return 8'hA1; 14: return 8'h86; default: return 8'h8E;
        endcase
    endfunction

    int        c;                   // clocks since reset released
    bit        m_valid;
    bit        m_stop;
    int        m_shd_nib[N];
    bit        m_shd_dp[N];
    bit        m_shd_blank[N];
    int        m_stg_nib[N];
    bit        m_stg_dp[N];
    bit        m_stg_blank[N];
    bit        m_pend;

    initial begin
        m_valid = 0;
        m_stop  = 0;
        c       = 0;
    end

    always @(posedge clk) begin
        int   d;
        bit   bnd;
        bit   sup;
        bit   gate;
        bit   dark;
        logic [N-1:0] e_sel;
        logic [7:0]   e_seg;
        if (!m_stop) begin
            if (rst) begin
                exp_q.push_back({1'b0, 1'b0, {N{1'b1}}, 8'hFF});
                c = 0;
                m_pend = 0;
                for (int i = 0; i < N; i++) begin
                    m_shd_nib[i] = 0; m_shd_dp[i] = 0; m_shd_blank[i] = 0;
                    m_stg_nib[i] = 0; m_stg_dp[i] = 0; m_stg_blank[i] = 0;
                end
                m_valid = 1;
            end else if (m_valid) begin
                d   = (c / SD) % N;
                bnd = (c % FRAME) == FRAME - 1;
                sup = 0;
                if (lz_blank && d > 0) begin
                    sup = 1;
                    for (int j = d; j < N; j++)
                        if (m_shd_nib[j] != 0 || m_shd_dp[j]) sup = 0;
                end
                gate = (int'(brightness) == (1 << BW) - 1) || ((c % (1 << BW)) < int'(brightness));
                dark = m_shd_blank[d] || sup || !gate;
                if (dark) begin
                    e_sel = '1;
                    e_seg = 8'hFF;
                end else begin
                    e_sel = '1;
                    e_sel[d] = 1'b0;
                    e_seg = seg_of(m_shd_nib[d]);
                    if (m_shd_dp[d]) e_seg[7] = 1'b0;
                end
                exp_q.push_back({bnd && (load || m_pend), bnd, e_sel, e_seg});
                if (load) begin
                    for (int i = 0; i < N; i++) begin
                        if (bnd) begin
                            m_shd_nib[i]   = int'(disp_data[4*i +: 4]);
                            m_shd_dp[i]    = dp_in[i];
                            m_shd_blank[i] = blank_in[i];
                        end else begin
                            m_stg_nib[i]   = int'(disp_data[4*i +: 4]);
                            m_stg_dp[i]    = dp_in[i];
                            m_stg_blank[i] = blank_in[i];
                        end
                    end
                    m_pend = !bnd;
                end else if (bnd && m_pend) begin
                    m_shd_nib   = m_stg_nib;
                    m_shd_dp    = m_stg_dp;
                    m_shd_blank = m_stg_blank;
                    m_pend = 0;
                end
                c = c + 1;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {load_ack, frame_start, sel, seg};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL outputs t=%0t got ack=%b fs=%b sel=%h seg=%h, expected ack=%b fs=%b sel=%h seg=%h",
                         $time, act_v[W-1], act_v[W-2], act_v[8 +: N], act_v[7:0],
                         exp_v[W-1], exp_v[W-2], exp_v[8 +: N], exp_v[7:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [4*N-1:0] d, input logic [N-1:0] dp, input logic [N-1:0] bl);
        disp_data = d;
        dp_in     = dp;
        blank_in  = bl;
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
    endtask

    // Return at the falling edge just before a boundary clock.
    task automatic wait_pre_boundary();
        bit found;
        found = 0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (c % FRAME == FRAME - 1) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        if (!found) begin
            n_err++;
            $display("FAIL boundary_wait: boundary not reached within %0d clocks", 2 * FRAME);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        disp_data = '0;
        dp_in = '0;
        blank_in = '0;
        lz_blank = 1'b0;
        brightness = '1;
        load = 1'b0;

        // reset held for 3 clocks
        run(3);
        rst = 1'b0;

        // basic hex display
        run(5);
        do_load(16'h12AB, 4'b0000, 4'b0000);
        run(3 * FRAME);

        // leading-zero suppression, then a dp that stops the suppression
        lz_blank = 1'b1;
        do_load(16'h0050, 4'b0000, 4'b0000);
        run(2 * FRAME + 3);
        do_load(16'h0050, 4'b1000, 4'b0000);
        run(2 * FRAME);
        lz_blank = 1'b0;

        // brightness
        brightness = 2'd1;
        run(2 * FRAME);
        brightness = 2'd0;
        run(2 * FRAME);
        brightness = 2'd2;
        run(FRAME);
        brightness = 2'd3;

        // load on the boundary clock itself
        wait_pre_boundary();
        do_load(16'hBEEF, 4'b0101, 4'b0000);
        run(2 * FRAME);

        // two loads within one frame: the last one wins
        wait_pre_boundary();
        run(2);
        do_load(16'h1111, 4'b0000, 4'b0000);
        run(3);
        do_load(16'h2222, 4'b0000, 4'b0010);
        run(2 * FRAME);

        // reset with a load pending: the load is dropped
        do_load(16'h3333, 4'b0000, 4'b0000);
        run(2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run(2 * FRAME);

        // randomized traffic
        for (int k = 0; k < 1500; k++) begin
            load = ($urandom_range(0, 7) == 0);
            if (load) begin
                disp_data = 16'($urandom());
                if ($urandom_range(0, 2) == 0) disp_data[15:8] = 8'h00;
                dp_in     = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'b0000;
                blank_in  = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'b0000;
            end
            if ($urandom_range(0, 30) == 0) lz_blank = ~lz_blank;
            if ($urandom_range(0, 40) == 0)
                brightness = ($urandom_range(0, 1) == 0) ? 2'd3 : 2'($urandom());
            rst = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        load = 1'b0;
        rst  = 1'b0;
        run(2);

        // stop the model and make sure every expected entry was consumed
        m_stop = 1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
